// File: rtl/alu_cmd_issuer.sv
// Initiator for the TotalALU command interface: takes one request at a time, drives
// funct/operands, waits the ALU latency and returns one beat (two, HI then LO, for MULTU/DIVU).
module alu_cmd_issuer #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [5:0]       alu_signal,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    input  logic [WIDTH-1:0] alu_output,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_hi,
    output logic             rsp_err
);

    localparam int MAXL = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    localparam logic [5:0] OP_MFHI = 6'd16;
    localparam logic [5:0] OP_MFLO = 6'd18;

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_MUL_WAIT, S_MFHI, S_RSP_HI, S_MFLO, S_RSP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_req_ready, w_ready_nxt;
    logic [5:0]       r_alu_signal, w_sig_nxt;
    logic [WIDTH-1:0] r_alu_a, w_a_nxt;
    logic [WIDTH-1:0] r_alu_b, w_b_nxt;
    logic             r_rsp_valid, w_vld_nxt;
    logic [WIDTH-1:0] r_rsp_data, w_data_nxt;
    logic             r_rsp_hi, w_hi_nxt;
    logic             r_rsp_err, w_err_nxt;

    function automatic logic is_single(input logic [5:0] op);
        case (op)
            6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd2: is_single = 1'b1;
            default:                                       is_single = 1'b0;
        endcase
    endfunction

    function automatic logic is_muldiv(input logic [5:0] op);
        is_muldiv = (op == 6'd25) || (op == 6'd27);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sig_nxt   = r_alu_signal;
        w_a_nxt     = r_alu_a;
        w_b_nxt     = r_alu_b;
        w_vld_nxt   = r_rsp_valid;
        w_data_nxt  = r_rsp_data;
        w_hi_nxt    = r_rsp_hi;
        w_err_nxt   = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    if (is_single(req_op)) begin
                        w_sig_nxt   = req_op;
                        w_a_nxt     = req_a;
                        w_b_nxt     = req_b;
                        w_cnt_nxt   = CW'(ALU_LAT);
                        w_state_nxt = S_EXEC;
                    end else if (is_muldiv(req_op)) begin
                        w_sig_nxt   = req_op;
                        w_a_nxt     = req_a;
                        w_b_nxt     = req_b;
                        w_cnt_nxt   = CW'(MUL_LAT);
                        w_state_nxt = S_MUL_WAIT;
                    end else begin
                        // Unsupported op never reaches the ALU; answer with an error beat.
                        w_vld_nxt   = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_data_nxt  = '0;
                        w_hi_nxt    = 1'b0;
                        w_state_nxt = S_RSP;
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == CW'(1)) begin
                    w_data_nxt  = alu_output;
                    w_vld_nxt   = 1'b1;
                    w_hi_nxt    = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_RSP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_MUL_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_sig_nxt   = OP_MFHI;
                    w_cnt_nxt   = CW'(ALU_LAT);
                    w_state_nxt = S_MFHI;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_MFHI: begin
                if (r_cnt == CW'(1)) begin
                    w_data_nxt  = alu_output;
                    w_hi_nxt    = 1'b1;
                    w_vld_nxt   = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_RSP_HI;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RSP_HI: begin
                if (rsp_ready) begin
                    w_sig_nxt   = OP_MFLO;
                    w_cnt_nxt   = CW'(ALU_LAT);
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = S_MFLO;
                end
            end
            S_MFLO: begin
                if (r_cnt == CW'(1)) begin
                    w_data_nxt  = alu_output;
                    w_hi_nxt    = 1'b0;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = S_RSP;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_vld_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_alu_signal <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_hi     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_req_ready  <= w_ready_nxt;
            r_alu_signal <= w_sig_nxt;
            r_alu_a      <= w_a_nxt;
            r_alu_b      <= w_b_nxt;
            r_rsp_valid  <= w_vld_nxt;
            r_rsp_data   <= w_data_nxt;
            r_rsp_hi     <= w_hi_nxt;
            r_rsp_err    <= w_err_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_signal = r_alu_signal;
    assign alu_dataA  = r_alu_a;
    assign alu_dataB  = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_hi     = r_rsp_hi;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural TotalALU (HI/LO latched after MUL_LAT held cycles).
module tb_alu_cmd_issuer;

    localparam int WIDTH   = 32;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 22;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [5:0]       req_op = '0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [5:0]       alu_signal;
    logic [WIDTH-1:0] alu_dataA;
    logic [WIDTH-1:0] alu_dataB;
    logic [WIDTH-1:0] alu_output;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_hi;
    logic             rsp_err;

    int checks = 0;
    int errors = 0;

    alu_cmd_issuer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_signal(alu_signal), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
        .alu_output(alu_output),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hi(rsp_hi), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural TotalALU
    logic [WIDTH-1:0] m_hi, m_lo;
    int               m_held;
    logic [63:0]      m_prod;
    assign m_prod = 64'(alu_dataA) * 64'(alu_dataB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_held <= 0;
        end else if (alu_signal == 6'd25 || alu_signal == 6'd27) begin
            m_held <= m_held + 1;
            if (m_held == MUL_LAT - 1) begin
                if (alu_signal == 6'd25) begin
                    m_hi <= m_prod[63:32];
                    m_lo <= m_prod[31:0];
                end else if (alu_dataB != 0) begin
                    m_hi <= alu_dataA % alu_dataB;
                    m_lo <= alu_dataA / alu_dataB;
                end
            end
        end else begin
            m_held <= 0;
        end
    end

    always_comb begin
        alu_output = '0;
        case (alu_signal)
            6'd36: alu_output = alu_dataA & alu_dataB;
            6'd37: alu_output = alu_dataA | alu_dataB;
            6'd32: alu_output = alu_dataA + alu_dataB;
            6'd34: alu_output = alu_dataA - alu_dataB;
            6'd42: alu_output = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            6'd0:  alu_output = alu_dataA << alu_dataB[4:0];
            6'd2:  alu_output = alu_dataA >> alu_dataB[4:0];
            6'd16: alu_output = m_hi;
            6'd18: alu_output = m_lo;
            default: alu_output = '0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns #1 after the edge on which it was accepted.
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 100) begin step(); n++; end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout op=%0d req_ready=%b required 1", op, req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    // Waits for a beat (rsp_ready assumed high), samples it, and steps past its handshake.
    task automatic get_beat(output logic [31:0] d, output logic h, output logic e);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
        if (rsp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
        end
        d = rsp_data; h = rsp_hi; e = rsp_err;
        step();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) step();
        checks++;
        if ({req_ready, rsp_valid, rsp_hi, rsp_err} !== 4'b0000 || alu_signal !== 6'd0 ||
            alu_dataA !== 0 || alu_dataB !== 0 || rsp_data !== 0) begin
            errors++;
            $display("FAIL reset_state ready=%b vld=%b hi=%b err=%b sig=%0d A=%0h B=%0h data=%0h required all 0",
                     req_ready, rsp_valid, rsp_hi, rsp_err, alu_signal, alu_dataA, alu_dataB, rsp_data);
        end
        reset = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %b required 1", req_ready);
        end
    endtask

    task automatic test_add();
        send(6'd32, 32'd5, 32'd7);
        checks++;
        if (alu_signal !== 6'd32 || alu_dataA !== 32'd5 || alu_dataB !== 32'd7) begin
            errors++; $display("FAIL add_drive sig=%0d A=%0d B=%0d required 32/5/7", alu_signal, alu_dataA, alu_dataB);
        end
        for (int i = 1; i < ALU_LAT + 1; i++) begin
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL add_early_valid cycle %0d got %b required 0", i, rsp_valid);
            end
            step();
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_hi !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL add_beat vld=%b data=%0d hi=%b err=%b required 1/12/0/0", rsp_valid, rsp_data, rsp_hi, rsp_err);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL add_done vld=%b ready=%b required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_multu();
        int n;
        logic [31:0] d; logic h, e;
        send(6'd25, 32'd65536, 32'd65536);
        n = 1;
        checks++;
        if (alu_signal !== 6'd25) begin
            errors++; $display("FAIL multu_drive sig=%0d required 25", alu_signal);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            if (alu_signal != 6'd25) break;
            n++;
        end
        checks++;
        if (n != MUL_LAT || alu_signal !== 6'd16) begin
            errors++; $display("FAIL multu_hold held=%0d sig=%0d required %0d/16", n, alu_signal, MUL_LAT);
        end
        get_beat(d, h, e);
        checks++;
        if (h !== 1'b1 || d !== 32'd1 || e !== 1'b0) begin
            errors++; $display("FAIL multu_hi hi=%b data=%0h err=%b required 1/1/0", h, d, e);
        end
        checks++;
        if (alu_signal !== 6'd18) begin
            errors++; $display("FAIL multu_mflo sig=%0d required 18", alu_signal);
        end
        get_beat(d, h, e);
        checks++;
        if (h !== 1'b0 || d !== 32'd0 || e !== 1'b0) begin
            errors++; $display("FAIL multu_lo hi=%b data=%0h err=%b required 0/0/0", h, d, e);
        end
    endtask

    task automatic test_divu_stall();
        logic [31:0] d;
        logic h;
        logic [31:0] exp_d [2];
        logic        exp_h [2];
        int n;
        exp_d[0] = 32'd2;  exp_h[0] = 1'b1;
        exp_d[1] = 32'd14; exp_h[1] = 1'b0;
        rsp_ready = 1'b0;
        send(6'd27, 32'd100, 32'd7);
        for (int beat = 0; beat < 2; beat++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 200) begin
                checks++;
                if (req_ready !== 1'b0) begin
                    errors++; $display("FAIL divu_busy_ready beat %0d got %b required 0", beat, req_ready);
                end
                step(); n++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d[beat] || rsp_hi !== exp_h[beat]) begin
                errors++; $display("FAIL divu_beat%0d vld=%b data=%0d hi=%b required 1/%0d/%b",
                                   beat, rsp_valid, rsp_data, rsp_hi, exp_d[beat], exp_h[beat]);
            end
            d = rsp_data; h = rsp_hi;
            for (int s = 0; s < 4; s++) begin
                step();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_hi !== h || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                    errors++; $display("FAIL divu_stall%0d cyc %0d vld=%b data=%0d hi=%b err=%b ready=%b required 1/%0d/%b/0/0",
                                       beat, s, rsp_valid, rsp_data, rsp_hi, rsp_err, req_ready, d, h);
                end
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++; $display("FAIL divu_consume%0d vld=%b required 0", beat, rsp_valid);
            end
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL divu_idle ready=%b required 1", req_ready);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_unsupported();
        logic [31:0] d; logic h, e;
        send(6'd63, 32'd1, 32'd1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_hi !== 1'b0) begin
            errors++; $display("FAIL bad_op_beat vld=%b err=%b data=%0h hi=%b required 1/1/0/0", rsp_valid, rsp_err, rsp_data, rsp_hi);
        end
        checks++;
        if (alu_signal !== 6'd18 || alu_dataA !== 32'd100 || alu_dataB !== 32'd7) begin
            errors++; $display("FAIL bad_op_alu sig=%0d A=%0d B=%0d required 18/100/7", alu_signal, alu_dataA, alu_dataB);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL bad_op_clear vld=%b err=%b required 0/0", rsp_valid, rsp_err);
        end
        send(6'd32, 32'd2, 32'd3);
        get_beat(d, h, e);
        checks++;
        if (d !== 32'd5 || h !== 1'b0 || e !== 1'b0) begin
            errors++; $display("FAIL add_after_err data=%0d hi=%b err=%b required 5/0/0", d, h, e);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] d; logic h, e;
        int stray = 0;
        send(6'd25, 32'd3, 32'd4);
        repeat (10) step();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_hi, rsp_err} !== 4'b0000 || alu_signal !== 6'd0 ||
            alu_dataA !== 0 || alu_dataB !== 0 || rsp_data !== 0) begin
            errors++;
            $display("FAIL async_reset ready=%b vld=%b hi=%b err=%b sig=%0d A=%0h B=%0h data=%0h required all 0",
                     req_ready, rsp_valid, rsp_hi, rsp_err, alu_signal, alu_dataA, alu_dataB, rsp_data);
        end
        repeat (2) step();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rsp_valid !== 1'b0 || alu_signal !== 6'd0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL stray_after_reset cycles=%0d required 0", stray);
        end
        send(6'd42, 32'd3, 32'd5);
        get_beat(d, h, e);
        checks++;
        if (d !== 32'd1 || h !== 1'b0 || e !== 1'b0) begin
            errors++; $display("FAIL slt data=%0d hi=%b err=%b required 1/0/0", d, h, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic h, e;
        send(6'd34, 32'd3, 32'd10);
        req_op = 6'd2; req_a = 32'd16; req_b = 32'd2; req_valid = 1'b1;
        checks++;
        if (alu_signal !== 6'd34) begin
            errors++; $display("FAIL sub_drive sig=%0d required 34", alu_signal);
        end
        get_beat(d, h, e);
        checks++;
        if (d !== 32'hFFFFFFF9 || e !== 1'b0) begin
            errors++; $display("FAIL sub_beat data=%0h err=%b required fffffff9/0", d, e);
        end
        checks++;
        if (alu_signal !== 6'd34 || req_ready !== 1'b1) begin
            errors++; $display("FAIL held_req_ignored sig=%0d ready=%b required 34/1", alu_signal, req_ready);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (alu_signal !== 6'd2 || alu_dataA !== 32'd16) begin
            errors++; $display("FAIL srl_drive sig=%0d A=%0d required 2/16", alu_signal, alu_dataA);
        end
        get_beat(d, h, e);
        checks++;
        if (d !== 32'd4 || e !== 1'b0 || h !== 1'b0) begin
            errors++; $display("FAIL srl_beat data=%0d hi=%b err=%b required 4/0/0", d, h, e);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_multu();
        test_divu_stall();
        test_unsupported();
        test_reset_mid_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
